// File: rtl/mac_accumulator_pkg.sv
// Shared types for the MAC accumulator: FSM state encoding and counter sizing.
package mac_accumulator_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Product counter width; a single-product dot-product still gets one bit.
  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational sign-extend, add and clamp of one product into the accumulator.
// Sum is formed one bit wider than the accumulator so overflow is a simple sign check.
module sat_add #(
  parameter int IN_W  = 34,
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  addend,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] add_ext;
  logic [ACC_W:0] wide;

  assign acc_ext = {acc[ACC_W-1], acc};
  assign add_ext = {{(ACC_W+1-IN_W){addend[IN_W-1]}}, addend};
  assign wide    = acc_ext + add_ext;

  // Top two bits disagree only when the true sum left the ACC_W-bit range.
  always_comb begin
    sat = 1'b0;
    sum = wide[ACC_W-1:0];
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sat = 1'b1;
      sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Sums LEN signed products into a saturating accumulator and holds each result
// on a valid/ready output; input is stalled while a result is held.
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int WIDTH     = 17,
  parameter int ACC_WIDTH = 40,
  parameter int LEN       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*WIDTH-1:0]     product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   overflow
);

  localparam int            PW   = 2 * WIDTH;
  localparam int            CW   = cnt_width(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [CW-1:0]          cnt_q;
  logic                   ovf_q;
  logic [ACC_WIDTH-1:0]   acc_out_q;
  logic                   overflow_q;

  logic [ACC_WIDTH-1:0]   step_sum;
  logic                   step_sat;
  logic                   accept;
  logic                   last;

  sat_add #(
    .IN_W  (PW),
    .ACC_W (ACC_WIDTH)
  ) u_sat_add (
    .acc    (acc_q),
    .addend (product),
    .sum    (step_sum),
    .sat    (step_sat)
  );

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign acc_out   = acc_out_q;
  assign overflow  = overflow_q;

  assign accept = in_valid && in_ready;
  assign last   = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (accept && last) state_d = ST_HOLD;
      ST_HOLD:  if (out_ready)      state_d = ST_ACCUM;
      default:                      state_d = ST_ACCUM;
    endcase
    if (clear) state_d = ST_ACCUM;
  end

  // Clear drops both the partial sum and any product offered alongside it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      acc_out_q  <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      acc_out_q  <= '0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      if (last) begin
        acc_out_q  <= step_sum;
        overflow_q <= ovf_q | step_sat;
        acc_q      <= '0;
        cnt_q      <= '0;
        ovf_q      <= 1'b0;
      end else begin
        acc_q <= step_sum;
        cnt_q <= cnt_q + CW'(1);
        ovf_q <= ovf_q | step_sat;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench: three builds (LEN=8/ACC=40, LEN=8/ACC=34, LEN=1/ACC=40) on one clock.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Main build
  logic        a_clear = 0, a_in_valid = 0, a_out_ready = 0;
  logic        a_in_ready, a_out_valid, a_overflow;
  logic [33:0] a_product = '0;
  logic [39:0] a_acc_out;

  // Narrow accumulator build for saturation
  logic        s_clear = 0, s_in_valid = 0, s_out_ready = 0;
  logic        s_in_ready, s_out_valid, s_overflow;
  logic [33:0] s_product = '0;
  logic [33:0] s_acc_out;

  // Single-product build
  logic        o_clear = 0, o_in_valid = 0, o_out_ready = 0;
  logic        o_in_ready, o_out_valid, o_overflow;
  logic [33:0] o_product = '0;
  logic [39:0] o_acc_out;

  mac_accumulator #(.WIDTH(17), .ACC_WIDTH(40), .LEN(8)) u_main (
    .clk(clk), .reset(rst_n), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .product(a_product), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .acc_out(a_acc_out), .overflow(a_overflow));

  mac_accumulator #(.WIDTH(17), .ACC_WIDTH(34), .LEN(8)) u_sat (
    .clk(clk), .reset(rst_n), .clear(s_clear), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .product(s_product), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .acc_out(s_acc_out), .overflow(s_overflow));

  mac_accumulator #(.WIDTH(17), .ACC_WIDTH(40), .LEN(1)) u_one (
    .clk(clk), .reset(rst_n), .clear(o_clear), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .product(o_product), .out_valid(o_out_valid), .out_ready(o_out_ready),
    .acc_out(o_acc_out), .overflow(o_overflow));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted product on the main build; checks that it was really takeable.
  task automatic a_push(input logic [33:0] p);
    vec_cnt++;
    if (a_in_ready !== 1'b1) begin
      err_cnt++; $display("FAIL push_ready: in_ready=%0b required 1", a_in_ready);
    end
    a_in_valid = 1'b1; a_product = p;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic s_push(input logic [33:0] p);
    s_in_valid = 1'b1; s_product = p;
    tick();
    s_in_valid = 1'b0;
  endtask

  task automatic a_release();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b1; a_product = 34'd5;
    s_in_valid = 1'b1; s_product = 34'd5;
    o_in_valid = 1'b1; o_product = 34'd5;
    tick(); tick();
    vec_cnt++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      err_cnt++; $display("FAIL reset_hs: in_ready=%0b out_valid=%0b required 1/0", a_in_ready, a_out_valid);
    end
    vec_cnt++;
    if (a_acc_out !== 40'd0 || a_overflow !== 1'b0) begin
      err_cnt++; $display("FAIL reset_out: acc_out=%0d ovf=%0b required 0/0", a_acc_out, a_overflow);
    end
    vec_cnt++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
      err_cnt++; $display("FAIL reset_other: one_ov=%0b one_ir=%0b sat_ov=%0b required 0/1/0",
                          o_out_valid, o_in_ready, s_out_valid);
    end
    a_in_valid = 1'b0; s_in_valid = 1'b0; o_in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_dot_product();
    logic signed [33:0] p [8];
    p = '{34'sd3, -34'sd5, 34'sd7, 34'sd100, -34'sd1, 34'sd0, 34'sd2, 34'sd10};
    for (int i = 0; i < 8; i++) a_push(p[i]);
    vec_cnt++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
      err_cnt++; $display("FAIL dot_hs: out_valid=%0b in_ready=%0b required 1/0", a_out_valid, a_in_ready);
    end
    vec_cnt++;
    if (a_acc_out !== 40'd116 || a_overflow !== 1'b0) begin
      err_cnt++; $display("FAIL dot_sum: acc_out=%0d ovf=%0b required 116/0", $signed(a_acc_out), a_overflow);
    end
    tick();
    vec_cnt++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
      err_cnt++; $display("FAIL dot_hold: out_valid=%0b in_ready=%0b required 1/0", a_out_valid, a_in_ready);
    end
    a_release();
    vec_cnt++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      err_cnt++; $display("FAIL dot_release: out_valid=%0b in_ready=%0b required 0/1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 8; i++) a_push(34'(i));
    a_in_valid = 1'b1; a_product = 34'd99;
    for (int c = 0; c < 5; c++) begin
      tick();
      vec_cnt++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_acc_out !== 40'd36) begin
        err_cnt++; $display("FAIL bp_hold[%0d]: out_valid=%0b in_ready=%0b acc_out=%0d required 1/0/36",
                            c, a_out_valid, a_in_ready, a_acc_out);
      end
    end
    a_in_valid = 1'b0;
    a_release();
    for (int i = 0; i < 8; i++) a_push(34'd1);
    vec_cnt++;
    if (a_out_valid !== 1'b1 || a_acc_out !== 40'd8) begin
      err_cnt++; $display("FAIL bp_restart: out_valid=%0b acc_out=%0d required 1/8", a_out_valid, a_acc_out);
    end
    a_release();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) s_push(34'h1_FFFF_FFFF);
    vec_cnt++;
    if (s_out_valid !== 1'b1 || s_acc_out !== 34'h1_FFFF_FFFF || s_overflow !== 1'b1) begin
      err_cnt++; $display("FAIL sat_pos: out_valid=%0b acc_out=%0h ovf=%0b required 1/1ffffffff/1",
                          s_out_valid, s_acc_out, s_overflow);
    end
    s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) s_push(34'(i));
    vec_cnt++;
    if (s_acc_out !== 34'd36 || s_overflow !== 1'b0) begin
      err_cnt++; $display("FAIL sat_clean: acc_out=%0d ovf=%0b required 36/0", s_acc_out, s_overflow);
    end
    s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) s_push(34'h2_0000_0000);
    vec_cnt++;
    if (s_acc_out !== 34'h2_0000_0000 || s_overflow !== 1'b1) begin
      err_cnt++; $display("FAIL sat_neg: acc_out=%0h ovf=%0b required 200000000/1", s_acc_out, s_overflow);
    end
    s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) a_push(34'd1);
    a_clear = 1'b1; a_in_valid = 1'b1; a_product = 34'd50;
    tick();
    a_clear = 1'b0; a_in_valid = 1'b0;
    vec_cnt++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      err_cnt++; $display("FAIL clear_accum: out_valid=%0b in_ready=%0b required 0/1", a_out_valid, a_in_ready);
    end
    for (int i = 0; i < 8; i++) a_push(34'd2);
    vec_cnt++;
    if (a_out_valid !== 1'b1 || a_acc_out !== 40'd16) begin
      err_cnt++; $display("FAIL clear_sum: out_valid=%0b acc_out=%0d required 1/16", a_out_valid, a_acc_out);
    end
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    vec_cnt++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      err_cnt++; $display("FAIL clear_hold: out_valid=%0b in_ready=%0b required 0/1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_len1();
    o_in_valid = 1'b1; o_product = -34'sd7;
    tick();
    o_in_valid = 1'b0;
    vec_cnt++;
    if (o_out_valid !== 1'b1 || o_acc_out !== -40'sd7) begin
      err_cnt++; $display("FAIL len1_a: out_valid=%0b acc_out=%0d required 1/-7", o_out_valid, $signed(o_acc_out));
    end
    tick(); tick();
    vec_cnt++;
    if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0) begin
      err_cnt++; $display("FAIL len1_hold: out_valid=%0b in_ready=%0b required 1/0", o_out_valid, o_in_ready);
    end
    o_out_ready = 1'b1; tick(); o_out_ready = 1'b0;
    tick(); tick();
    o_in_valid = 1'b1; o_product = 34'sd9;
    tick();
    o_in_valid = 1'b0;
    vec_cnt++;
    if (o_out_valid !== 1'b1 || o_acc_out !== 40'sd9 || o_overflow !== 1'b0) begin
      err_cnt++; $display("FAIL len1_b: out_valid=%0b acc_out=%0d ovf=%0b required 1/9/0",
                          o_out_valid, $signed(o_acc_out), o_overflow);
    end
    o_out_ready = 1'b1; tick(); o_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dot_product();
    test_backpressure();
    test_saturation();
    test_clear();
    test_len1();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
